// File: rtl/arb_pkg.sv
// Shared encodings and default widths for the two-port round-robin stream arbiter.
package arb_pkg;
    localparam logic PORT1     = 1'b0;
    localparam logic PORT2     = 1'b1;
    localparam int   N_DEF     = 32;
    localparam int   CNT_W_DEF = 16;
endpackage

// File: rtl/mux_param_structural.sv
// Structural N-bit 2:1 mux: one AND-OR cell per bit, sel=0 picks in1.
module mux_param_structural #(
    parameter int N = 32
) (
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         sel,
    output logic [N-1:0] out
);
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign out[i] = (in1[i] & ~sel) | (in2[i] & sel);
    end
endmodule

// File: rtl/rr_arb2_stream.sv
// Two-input round-robin stream arbiter with a one-entry registered output stage
// and per-port accept counters; the grant also drives the data mux select.
module rr_arb2_stream
    import arb_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in1_valid,
    input  logic [N-1:0]     in1_data,
    output logic             in1_ready,
    input  logic             in2_valid,
    input  logic [N-1:0]     in2_data,
    output logic             in2_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);
    logic             last, last_nxt;
    logic             grant, load_en, accept;
    logic             out_valid_nxt;
    logic [N-1:0]     out_data_nxt, mux_out;
    logic [CNT_W-1:0] cnt1_nxt, cnt2_nxt;

    mux_param_structural #(.N(N)) u_mux (
        .in1 (in1_data),
        .in2 (in2_data),
        .sel (grant),
        .out (mux_out)
    );

    // With no requester the grant parks on last so sel does not toggle.
    always_comb begin
        grant = last;
        case ({in1_valid, in2_valid})
            2'b10:   grant = PORT1;
            2'b01:   grant = PORT2;
            2'b11:   grant = ~last;
            default: grant = last;
        endcase
    end

    assign sel       = grant;
    assign load_en   = ~out_valid | out_ready;
    // Readies are held low while reset is asserted so no producer sees a phantom accept.
    assign in1_ready = ~rst & load_en & (grant == PORT1);
    assign in2_ready = ~rst & load_en & (grant == PORT2);
    assign accept    = load_en & (grant == PORT1 ? in1_valid : in2_valid);

    always_comb begin
        last_nxt      = last;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        cnt1_nxt      = cnt1;
        cnt2_nxt      = cnt2;
        if (accept) begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = mux_out;
            last_nxt      = grant;
            if (grant == PORT1) cnt1_nxt = cnt1 + 1'b1;
            else                cnt2_nxt = cnt2 + 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= PORT2;
            out_valid <= 1'b0;
            out_data  <= '0;
            cnt1      <= '0;
            cnt2      <= '0;
        end else begin
            last      <= last_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            cnt1      <= cnt1_nxt;
            cnt2      <= cnt2_nxt;
        end
    end
endmodule

// File: tb/tb_rr_arb2_stream.sv
// Directed bench for rr_arb2_stream; a second instance with 2-bit counters covers wrap.
module tb_rr_arb2_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic        in1_valid, in2_valid, out_ready;
    logic [31:0] in1_data, in2_data;
    logic        in1_ready, in2_ready, out_valid, sel;
    logic [31:0] out_data;
    logic [15:0] cnt1, cnt2;
    logic        s_in1_ready, s_in2_ready, s_out_valid, s_sel;
    logic [31:0] s_out_data;
    logic [1:0]  s_cnt1, s_cnt2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rr_arb2_stream #(.N(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .in2_valid(in2_valid), .in2_data(in2_data), .in2_ready(in2_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel), .cnt1(cnt1), .cnt2(cnt2)
    );

    rr_arb2_stream #(.N(32), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(s_in1_ready),
        .in2_valid(in2_valid), .in2_data(in2_data), .in2_ready(s_in2_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready),
        .sel(s_sel), .cnt1(s_cnt1), .cnt2(s_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 32'h0000_00AA;
        in2_valid = 1'b1; in2_data = 32'h0000_00BB;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (cnt1 !== 16'd0 || cnt2 !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt1, cnt2); end
        checks++; if (in1_ready !== 1'b0 || in2_ready !== 1'b0) begin errors++; $display("FAIL reset_readies got=%b%b exp=00", in1_ready, in2_ready); end
        rst = 1'b0;
        #1;
        checks++; if (sel !== 1'b0 || in1_ready !== 1'b1 || in2_ready !== 1'b0) begin
            errors++; $display("FAIL reset_first_grant got sel=%b rdy=%b%b exp sel=0 rdy=10", sel, in1_ready, in2_ready);
        end
        in1_valid = 1'b0; in2_valid = 1'b0;
    endtask

    task automatic test_single();
        in1_valid = 1'b1; in1_data = 32'h0000_0017; in2_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in1_ready !== 1'b1 || in2_ready !== 1'b0 || sel !== 1'b0) begin
            errors++; $display("FAIL single_grant got sel=%b rdy=%b%b exp sel=0 rdy=10", sel, in1_ready, in2_ready);
        end
        step();
        in1_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0017) begin
            errors++; $display("FAIL single_out got v=%b d=%h exp v=1 d=00000017", out_valid, out_data);
        end
        checks++; if (cnt1 !== 16'd1 || cnt2 !== 16'd0) begin errors++; $display("FAIL single_cnt got=%0d/%0d exp=1/0", cnt1, cnt2); end
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0000_0017) begin
            errors++; $display("FAIL single_drain got v=%b d=%h exp v=0 d=00000017", out_valid, out_data);
        end
    endtask

    task automatic test_alternation();
        logic [31:0] exp_d;
        reset_pulse();
        in1_valid = 1'b1; in1_data = 32'h0000_0001;
        in2_valid = 1'b1; in2_data = 32'h0000_1000; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            exp_d = (k % 2 == 0) ? 32'h0000_0001 : 32'h0000_1000;
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
                errors++; $display("FAIL alt_word%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_d);
            end
        end
        checks++; if (cnt1 !== 16'd3 || cnt2 !== 16'd3) begin errors++; $display("FAIL alt_cnt got=%0d/%0d exp=3/3", cnt1, cnt2); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        #1;
        checks++; if (in1_ready !== 1'b0 || in2_ready !== 1'b0) begin
            errors++; $display("FAIL bp_readies got=%b%b exp=00", in1_ready, in2_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_1000 || in1_ready !== 1'b0 || in2_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b%b exp v=1 d=00001000 rdy=00",
                                   k, out_valid, out_data, in1_ready, in2_ready);
            end
        end
        checks++; if (cnt1 !== 16'd3 || cnt2 !== 16'd3) begin errors++; $display("FAIL bp_cnt got=%0d/%0d exp=3/3", cnt1, cnt2); end
        out_ready = 1'b1;
        #1;
        checks++; if (sel !== 1'b0 || in1_ready !== 1'b1 || in2_ready !== 1'b0) begin
            errors++; $display("FAIL bp_release_grant got sel=%b rdy=%b%b exp sel=0 rdy=10", sel, in1_ready, in2_ready);
        end
        step();
        in1_valid = 1'b0; in2_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0001 || cnt1 !== 16'd4) begin
            errors++; $display("FAIL bp_release_word got v=%b d=%h c1=%0d exp v=1 d=00000001 c1=4", out_valid, out_data, cnt1);
        end
        step();
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp_c;
        reset_pulse();
        in2_valid = 1'b1; in2_data = 32'h0000_0005; out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_c = 2'(k);
            checks++; if (s_cnt2 !== exp_c) begin errors++; $display("FAIL wrap_cnt2_%0d got=%0d exp=%0d", k, s_cnt2, exp_c); end
            checks++; if (cnt2 !== 16'(k)) begin errors++; $display("FAIL wide_cnt2_%0d got=%0d exp=%0d", k, cnt2, k); end
        end
        in2_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_midstream();
        in1_valid = 1'b1; in1_data = 32'h0000_00C3; out_ready = 1'b1;
        step();
        in1_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_00C3) begin
            errors++; $display("FAIL mid_pre got v=%b d=%h exp v=1 d=000000c3", out_valid, out_data);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || cnt1 !== 16'd0 || cnt2 !== 16'd0) begin
            errors++; $display("FAIL mid_reset got v=%b d=%h c=%0d/%0d exp v=0 d=0 c=0/0", out_valid, out_data, cnt1, cnt2);
        end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_after got v=%b exp=0", out_valid); end
    endtask

    initial begin
        rst = 1'b1; in1_valid = 1'b0; in2_valid = 1'b0; out_ready = 1'b0;
        in1_data = '0; in2_data = '0;
        test_reset();
        test_single();
        test_alternation();
        test_backpressure();
        test_counter_wrap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
